control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Multi-cycle control FSM. Consumes the opcode field latched by the instruction register (ir) and issues every register enable, bus select, memory strobe and ALU op for fetch/decode/execute.
- Sits between ir, the pc/ar/ac registers, data memory and the ALU; it is the only driver of ir.write_en and ir.inc_en.

Parameters:
- OPW, 6, opcode width (matches ir.instruction).
- MEM_WAIT, 1, extra wait cycles inserted after each memory read/write strobe; range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; leaves IDLE when high.
- opcode  in  OPW  ir.instruction.
- z_flag  in  1  ALU zero flag, sampled in DECODE.
- bus_sel  out  3  bus source: 0 none, 1 PC, 2 IR operand, 3 MEM, 4 AC.
- ir_write_en  out  1  to ir.write_en.
- ir_inc_en  out  1  to ir.inc_en; held 0.
- pc_inc_en  out  1  PC increment.
- pc_write_en  out  1  PC load from bus.
- ar_write_en  out  1  AR load from bus.
- ac_write_en  out  1  AC load from ALU/bus.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- alu_op  out  3  0 PASS, 1 ADD, 2 SUB.
- halted  out  1  high while in HALT.
- illegal  out  1  one-cycle pulse on an unknown opcode.

Behaviour:
- Moore outputs decoded from the registered state. In every state, outputs not listed below are 0.
- Reset value of all outputs is 0; rst forces IDLE asynchronously from any state, including mid-instruction and mid-wait.
- Wait counter: 4 bits. Loaded with MEM_WAIT on entry to any MEMx state; the state holds while counter != 0, decrementing each cycle. With MEM_WAIT=0 a MEMx state lasts exactly 1 cycle.
- IDLE: stays in IDLE while run=0; run=1 -> F1.
- F1: bus_sel=1, ar_write_en=1 -> F2MEM.
- F2MEM: mem_read=1, held for 1+MEM_WAIT cycles. pc_inc_en=1 in the final cycle only -> F3.
- F3: bus_sel=3, ir_write_en=1 -> DEC. The opcode is valid from DEC onward.
- DEC: branches on opcode; z_flag is sampled here.
  - 0x00 NOP -> F1 (or IDLE if run=0).
  - 0x01 LDA, 0x02 STA, 0x03 ADD, 0x04 SUB -> EA.
  - 0x05 JMP -> JMP.
  - 0x06 JZ -> JMP if z_flag=1, else F1.
  - 0x3F HALT -> HALT.
  - Any other value: illegal=1 for this cycle, treated as NOP.
- EA: bus_sel=2, ar_write_en=1. STA -> STMEM; all others -> LDMEM.
- LDMEM: mem_read=1, held for 1+MEM_WAIT cycles -> EXE.
- EXE: bus_sel=3, ac_write_en=1. alu_op = 0 for LDA, 1 for ADD, 2 for SUB -> F1/IDLE.
- STMEM: bus_sel=4, mem_write=1, held for 1+MEM_WAIT cycles -> F1/IDLE.
- JMP: bus_sel=2, pc_write_en=1 -> F1/IDLE.
- HALT: halted=1. Exits only via rst; run is ignored.
- "F1/IDLE": go to F1 if run=1, else IDLE. run is sampled only at instruction boundaries; dropping run mid-instruction completes the current instruction.
- Instruction latency with MEM_WAIT=W, counted from F1 to the next F1:
  - NOP: 4+W.
  - JMP, taken JZ: 5+W.
  - LDA/ADD/SUB: 7+2W.
  - STA: 6+2W.
- Exactly one bus_sel source per cycle. mem_read and mem_write are never high together.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants (OP_NOP, OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_JMP, OP_JZ, OP_HALT);
  - bus_sel encodings (BUS_NONE..BUS_AC);
  - alu_op encodings;
  - the state enumeration.
- One sub-module: wait_counter (load, decrement, zero flag), shared with future memory-side blocks.
- The output decode stays inline as one case on state.

Test Plan:
- Reset/idle: rst pulse mid-LDMEM with MEM_WAIT=2 -> next edge state IDLE and all outputs 0. Release with run=0 -> remains IDLE for 10 cycles.
- Fetch: run=1, opcode=0x00, MEM_WAIT=0 -> F1 ar_write_en/bus_sel=1, F2 mem_read+pc_inc_en, F3 ir_write_en/bus_sel=3, DEC; next F1 at cycle 5.
- LDA/ADD/SUB with MEM_WAIT=2 -> mem_read high 3 cycles in LDMEM. EXE shows ac_write_en=1 with alu_op 0/1/2 respectively. Period is 11 cycles.
- STA with MEM_WAIT=1 -> mem_write high exactly 2 cycles with bus_sel=4; mem_read=0 throughout STMEM.
- JZ with z_flag=1 -> JMP state, pc_write_en=1, bus_sel=2. JZ with z_flag=0 -> F1 directly, pc_write_en never asserted.
- opcode=0x2A -> illegal pulses 1 cycle in DEC, then F1. opcode=0x3F -> halted=1 stays high for 20 cycles with run toggling.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the control sequencer: opcodes, bus sources, ALU ops and FSM states.
package cpu_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned BUS_W  = 3;
  localparam int unsigned ALU_W  = 3;
  localparam int unsigned WAIT_W = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 6'h00;
  localparam logic [OP_W-1:0] OP_LDA  = 6'h01;
  localparam logic [OP_W-1:0] OP_STA  = 6'h02;
  localparam logic [OP_W-1:0] OP_ADD  = 6'h03;
  localparam logic [OP_W-1:0] OP_SUB  = 6'h04;
  localparam logic [OP_W-1:0] OP_JMP  = 6'h05;
  localparam logic [OP_W-1:0] OP_JZ   = 6'h06;
  localparam logic [OP_W-1:0] OP_HALT = 6'h3F;

  typedef enum logic [BUS_W-1:0] {
    BUS_NONE = 3'd0,
    BUS_PC   = 3'd1,
    BUS_IR   = 3'd2,
    BUS_MEM  = 3'd3,
    BUS_AC   = 3'd4
  } bus_sel_e;

  typedef enum logic [ALU_W-1:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2
  } alu_op_e;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_F1    = 4'd1,
    S_F2MEM = 4'd2,
    S_F3    = 4'd3,
    S_DEC   = 4'd4,
    S_EA    = 4'd5,
    S_LDMEM = 4'd6,
    S_EXE   = 4'd7,
    S_STMEM = 4'd8,
    S_JMP   = 4'd9,
    S_HALT  = 4'd10
  } state_e;

  // States that hold for the memory wait window.
  function automatic logic is_mem_state(input state_e s);
    return (s == S_F2MEM) || (s == S_LDMEM) || (s == S_STMEM);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter used to stretch memory strobes; saturates at zero.
module wait_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute controller; Moore outputs decoded from the state register.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned OPW      = 6,
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic           z_flag,
  output logic [2:0]     bus_sel,
  output logic           ir_write_en,
  output logic           ir_inc_en,
  output logic           pc_inc_en,
  output logic           pc_write_en,
  output logic           ar_write_en,
  output logic           ac_write_en,
  output logic           mem_read,
  output logic           mem_write,
  output logic [2:0]     alu_op,
  output logic           halted,
  output logic           illegal
);

  state_e state;
  state_e state_nxt;
  state_e boundary;
  logic   wait_load;
  logic   wait_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter is armed on the edge that enters a memory state.
  assign wait_load = is_mem_state(state_nxt) && (state_nxt != state);

  wait_counter #(.W(WAIT_W)) u_wait (
    .clk       (clk),
    .rst       (rst),
    .load      (wait_load),
    .load_value(WAIT_W'(MEM_WAIT)),
    .dec       (is_mem_state(state)),
    .zero_c    (wait_zero)
  );

  // run is only honoured at the end of an instruction.
  assign boundary = run ? S_F1 : S_IDLE;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (run) state_nxt = S_F1;
      S_F1:    state_nxt = S_F2MEM;
      S_F2MEM: if (wait_zero) state_nxt = S_F3;
      S_F3:    state_nxt = S_DEC;
      S_DEC: begin
        case (opcode)
          OPW'(OP_LDA), OPW'(OP_STA),
          OPW'(OP_ADD), OPW'(OP_SUB): state_nxt = S_EA;
          OPW'(OP_JMP):  state_nxt = S_JMP;
          OPW'(OP_JZ):   state_nxt = z_flag ? S_JMP : boundary;
          OPW'(OP_HALT): state_nxt = S_HALT;
          default:       state_nxt = boundary;
        endcase
      end
      S_EA:    state_nxt = (opcode == OPW'(OP_STA)) ? S_STMEM : S_LDMEM;
      S_LDMEM: if (wait_zero) state_nxt = S_EXE;
      S_EXE:   state_nxt = boundary;
      S_STMEM: if (wait_zero) state_nxt = boundary;
      S_JMP:   state_nxt = boundary;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus_sel     = BUS_NONE;
    ir_write_en = 1'b0;
    ir_inc_en   = 1'b0;
    pc_inc_en   = 1'b0;
    pc_write_en = 1'b0;
    ar_write_en = 1'b0;
    ac_write_en = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    alu_op      = ALU_PASS;
    halted      = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_F1: begin
        bus_sel     = BUS_PC;
        ar_write_en = 1'b1;
      end
      S_F2MEM: begin
        mem_read  = 1'b1;
        pc_inc_en = wait_zero;
      end
      S_F3: begin
        bus_sel     = BUS_MEM;
        ir_write_en = 1'b1;
      end
      S_DEC: begin
        case (opcode)
          OPW'(OP_NOP), OPW'(OP_LDA), OPW'(OP_STA), OPW'(OP_ADD),
          OPW'(OP_SUB), OPW'(OP_JMP), OPW'(OP_JZ), OPW'(OP_HALT): illegal = 1'b0;
          default: illegal = 1'b1;
        endcase
      end
      S_EA: begin
        bus_sel     = BUS_IR;
        ar_write_en = 1'b1;
      end
      S_LDMEM: mem_read = 1'b1;
      S_EXE: begin
        bus_sel     = BUS_MEM;
        ac_write_en = 1'b1;
        case (opcode)
          OPW'(OP_ADD): alu_op = ALU_ADD;
          OPW'(OP_SUB): alu_op = ALU_SUB;
          default:      alu_op = ALU_PASS;
        endcase
      end
      S_STMEM: begin
        bus_sel   = BUS_AC;
        mem_write = 1'b1;
      end
      S_JMP: begin
        bus_sel     = BUS_IR;
        pc_write_en = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: three sequencer instances (MEM_WAIT 0/1/2) share stimulus; per-cycle output vectors checked.
module tb_control_sequencer;
  import cpu_pkg::*;

  // Output vector layout: {bus_sel, irw, iri, pci, pcw, arw, acw, mr, mw, alu_op, halted, illegal}
  localparam logic [15:0] V_NONE = 16'h0000;
  localparam logic [15:0] V_F1   = {3'd1, 8'b00001000, 3'd0, 2'b00};
  localparam logic [15:0] V_F2W  = {3'd0, 8'b00000010, 3'd0, 2'b00};
  localparam logic [15:0] V_F2L  = {3'd0, 8'b00100010, 3'd0, 2'b00};
  localparam logic [15:0] V_F3   = {3'd3, 8'b10000000, 3'd0, 2'b00};
  localparam logic [15:0] V_ILL  = {3'd0, 8'b00000000, 3'd0, 2'b01};
  localparam logic [15:0] V_EA   = {3'd2, 8'b00001000, 3'd0, 2'b00};
  localparam logic [15:0] V_LD   = {3'd0, 8'b00000010, 3'd0, 2'b00};
  localparam logic [15:0] V_ST   = {3'd4, 8'b00000001, 3'd0, 2'b00};
  localparam logic [15:0] V_JMP  = {3'd2, 8'b00010000, 3'd0, 2'b00};
  localparam logic [15:0] V_HALT = {3'd0, 8'b00000000, 3'd0, 2'b10};

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        z_flag;
  logic [5:0]  opcode;
  logic [15:0] vecs [3];
  int          n_chk  = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [2:0] bus_sel;
    logic [2:0] alu_op;
    logic ir_write_en, ir_inc_en, pc_inc_en, pc_write_en, ar_write_en;
    logic ac_write_en, mem_read, mem_write, halted, illegal;

    control_sequencer #(.OPW(6), .MEM_WAIT(g)) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .opcode     (opcode),
      .z_flag     (z_flag),
      .bus_sel    (bus_sel),
      .ir_write_en(ir_write_en),
      .ir_inc_en  (ir_inc_en),
      .pc_inc_en  (pc_inc_en),
      .pc_write_en(pc_write_en),
      .ar_write_en(ar_write_en),
      .ac_write_en(ac_write_en),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .alu_op     (alu_op),
      .halted     (halted),
      .illegal    (illegal)
    );

    assign vecs[g] = {bus_sel, ir_write_en, ir_inc_en, pc_inc_en, pc_write_en,
                      ar_write_en, ac_write_en, mem_read, mem_write, alu_op,
                      halted, illegal};
  end

  function automatic logic [15:0] v_exe(input logic [2:0] a);
    return {3'd3, 8'b00000100, a, 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic exp_cyc(input string tag, input int w, input logic [15:0] e);
    @(negedge clk);
    chk(tag, vecs[w], e);
  endtask

  task automatic start(input logic [5:0] op, input logic z, input logic r);
    @(negedge clk);
    rst    = 1'b1;
    opcode = op;
    z_flag = z;
    run    = r;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fetch(input string tag, input int w);
    exp_cyc({tag, ".f1"}, w, V_F1);
    for (int i = 0; i < w; i++) exp_cyc({tag, ".f2wait"}, w, V_F2W);
    exp_cyc({tag, ".f2last"}, w, V_F2L);
    exp_cyc({tag, ".f3"}, w, V_F3);
  endtask

  initial begin
    logic [5:0] op;
    rst    = 1'b1;
    run    = 1'b0;
    z_flag = 1'b0;
    opcode = 6'h00;
    #2;
    for (int w = 0; w < 3; w++) chk("reset", vecs[w], V_NONE);

    // Async reset in the middle of an LDMEM wait, then idle with run low.
    start(OP_LDA, 1'b0, 1'b1);
    fetch("rstlda", 2);
    exp_cyc("rstlda.dec", 2, V_NONE);
    exp_cyc("rstlda.ea", 2, V_EA);
    exp_cyc("rstlda.ld0", 2, V_LD);
    exp_cyc("rstlda.ld1", 2, V_LD);
    rst = 1'b1;
    run = 1'b0;
    #1;
    chk("rst_async", vecs[2], V_NONE);
    @(negedge clk);
    chk("rst_hold", vecs[2], V_NONE);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) exp_cyc("idle", 2, V_NONE);
    run = 1'b1;
    exp_cyc("idle_exit", 2, V_F1);

    // NOP fetch with no wait states: next F1 on cycle 5.
    start(OP_NOP, 1'b0, 1'b1);
    fetch("nop", 0);
    exp_cyc("nop.dec", 0, V_NONE);
    exp_cyc("nop.next", 0, V_F1);

    // LDA/ADD/SUB with two wait states: 11-cycle period.
    for (int k = 0; k < 3; k++) begin
      op = (k == 0) ? OP_LDA : (k == 1) ? OP_ADD : OP_SUB;
      start(op, 1'b0, 1'b1);
      fetch("alu", 2);
      exp_cyc("alu.dec", 2, V_NONE);
      exp_cyc("alu.ea", 2, V_EA);
      for (int i = 0; i < 3; i++) exp_cyc("alu.ldmem", 2, V_LD);
      exp_cyc("alu.exe", 2, v_exe(3'(k)));
      exp_cyc("alu.next", 2, V_F1);
    end

    // STA with one wait state.
    start(OP_STA, 1'b0, 1'b1);
    fetch("sta", 1);
    exp_cyc("sta.dec", 1, V_NONE);
    exp_cyc("sta.ea", 1, V_EA);
    exp_cyc("sta.st0", 1, V_ST);
    exp_cyc("sta.st1", 1, V_ST);
    exp_cyc("sta.next", 1, V_F1);

    // Unconditional jump, one wait state.
    start(OP_JMP, 1'b0, 1'b1);
    fetch("jmp", 1);
    exp_cyc("jmp.dec", 1, V_NONE);
    exp_cyc("jmp.jmp", 1, V_JMP);
    exp_cyc("jmp.next", 1, V_F1);

    // JZ taken and not taken.
    start(OP_JZ, 1'b1, 1'b1);
    fetch("jz1", 0);
    exp_cyc("jz1.dec", 0, V_NONE);
    exp_cyc("jz1.jmp", 0, V_JMP);
    exp_cyc("jz1.next", 0, V_F1);
    start(OP_JZ, 1'b0, 1'b1);
    fetch("jz0", 0);
    exp_cyc("jz0.dec", 0, V_NONE);
    exp_cyc("jz0.next", 0, V_F1);
    exp_cyc("jz0.f2", 0, V_F2L);

    // Unknown opcode: one-cycle illegal pulse, then continue as NOP.
    start(6'h2A, 1'b0, 1'b1);
    fetch("ill", 0);
    exp_cyc("ill.dec", 0, V_ILL);
    exp_cyc("ill.next", 0, V_F1);
    exp_cyc("ill.f2", 0, V_F2L);

    // Dropping run mid-instruction completes it, then idles.
    start(OP_NOP, 1'b0, 1'b1);
    exp_cyc("drop.f1", 1, V_F1);
    run = 1'b0;
    exp_cyc("drop.f2wait", 1, V_F2W);
    exp_cyc("drop.f2last", 1, V_F2L);
    exp_cyc("drop.f3", 1, V_F3);
    exp_cyc("drop.dec", 1, V_NONE);
    exp_cyc("drop.idle0", 1, V_NONE);
    exp_cyc("drop.idle1", 1, V_NONE);

    // HALT holds regardless of run.
    start(OP_HALT, 1'b0, 1'b1);
    fetch("halt", 0);
    exp_cyc("halt.dec", 0, V_NONE);
    for (int i = 0; i < 20; i++) begin
      exp_cyc("halt.hold", 0, V_HALT);
      run = ~run;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
